// File: rtl/comperator_axi_ip_v1_0_block_matcher_pkg.sv
// rtl/comperator_axi_ip_v1_0_block_matcher_pkg.sv - shared types and widths for the block matcher
//
// Purpose: pixel/channel widths, matcher FSM state encoding and the
// width derivations used by the block matcher and its pixel cost helper.
// Ports: none (package).

package comperator_axi_ip_v1_0_block_matcher_pkg;

  localparam int DATA_WIDTH    = 24;
  localparam int CHANNEL_WIDTH = 8;
  localparam int COST_WIDTH    = 10;  // 3 * 255 = 765 fits in 10 bits

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_BOTH,
    ST_WAIT_BOTH,
    ST_FETCH_RIGHT,
    ST_WAIT_RIGHT,
    ST_ACCUM,
    ST_COMPARE,
    ST_RESULT
  } state_e;

  // Accumulated SAD over block_size pixels of at most 765 each.
  function automatic int sad_width(input int block_size);
    return COST_WIDTH + $clog2(block_size);
  endfunction

  // Candidate index width.
  function automatic int disp_width(input int max_disp);
    return $clog2(max_disp);
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comperator_axi_ip_v1_0_pixel_absdiff.sv
// rtl/comperator_axi_ip_v1_0_pixel_absdiff.sv - combinational RGB absolute-difference cost
//
// Purpose: cost = |dR| + |dG| + |dB| between two unsigned 24-bit RGB pixels.
// Ports:
//   i_pix_a  in  24  pixel A, R=[23:16] G=[15:8] B=[7:0]
//   i_pix_b  in  24  pixel B, same layout
//   o_cost   out 10  summed channel absolute differences (max 765)

module comperator_axi_ip_v1_0_pixel_absdiff
  import comperator_axi_ip_v1_0_block_matcher_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_pix_a,
  input  logic [DATA_WIDTH-1:0] i_pix_b,
  output logic [COST_WIDTH-1:0] o_cost
);

  function automatic logic [CHANNEL_WIDTH-1:0] ch_absdiff(
    input logic [CHANNEL_WIDTH-1:0] a,
    input logic [CHANNEL_WIDTH-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [CHANNEL_WIDTH-1:0] w_d_r;
  logic [CHANNEL_WIDTH-1:0] w_d_g;
  logic [CHANNEL_WIDTH-1:0] w_d_b;

  assign w_d_r = ch_absdiff(i_pix_a[23:16], i_pix_b[23:16]);
  assign w_d_g = ch_absdiff(i_pix_a[15:8],  i_pix_b[15:8]);
  assign w_d_b = ch_absdiff(i_pix_a[7:0],   i_pix_b[7:0]);

  assign o_cost = COST_WIDTH'(w_d_r) + COST_WIDTH'(w_d_g) + COST_WIDTH'(w_d_b);

endmodule

// File: rtl/comperator_axi_ip_v1_0_block_matcher.sv
// rtl/comperator_axi_ip_v1_0_block_matcher.sv - SAD block matcher over MAX_DISPARITY right candidates
//
// Purpose: fetch one left reference block, then MAX_DISPARITY right candidate
// blocks; report the candidate index with the smallest SAD (lowest index wins
// ties) on a valid/ready result port.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   start                  one-cycle match request, ignored while busy
//   busy                   match in progress until the result is accepted
//   left_go/right_go       one-cycle fetch pulses to the readers
//   left_done/right_done   reader done levels
//   left_block/right_block reader blocks, pixel i at [BLOCK_WIDTH-1-24*i -: 24]
//   result_valid/ready     result handshake
//   result_disparity       winning candidate index
//   result_sad             winning SAD

module comperator_axi_ip_v1_0_block_matcher
  import comperator_axi_ip_v1_0_block_matcher_pkg::*;
#(
  parameter int  BLOCK_SIZE    = 8,
  parameter int  MAX_DISPARITY = 16,
  localparam int BLOCK_WIDTH   = BLOCK_SIZE * DATA_WIDTH,
  localparam int DISP_W        = disp_width(MAX_DISPARITY),
  localparam int SAD_W         = sad_width(BLOCK_SIZE)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  output logic                   busy,
  output logic                   left_go,
  input  logic                   left_done,
  input  logic [BLOCK_WIDTH-1:0] left_block,
  output logic                   right_go,
  input  logic                   right_done,
  input  logic [BLOCK_WIDTH-1:0] right_block,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [DISP_W-1:0]      result_disparity,
  output logic [SAD_W-1:0]       result_sad
);

  localparam int PIX_W = cnt_width(BLOCK_SIZE);

  state_e r_state;
  state_e w_state_nxt;

  // Blocks start for one cycle after reset release so a start coincident
  // with release is not taken.
  logic                   r_armed;
  logic                   r_busy;
  logic                   r_left_go;
  logic                   r_right_go;
  logic                   r_result_valid;
  logic [DISP_W-1:0]      r_res_disp;
  logic [SAD_W-1:0]       r_res_sad;

  logic [DISP_W-1:0]      r_cand;
  logic [DISP_W-1:0]      r_best_disp;
  logic [SAD_W-1:0]       r_best_sad;
  logic [SAD_W-1:0]       r_sad;
  logic [PIX_W-1:0]       r_pix_cnt;
  logic [BLOCK_WIDTH-1:0] r_ref;
  logic [BLOCK_WIDTH-1:0] r_cand_blk;

  // Done levels are still high from the previous fetch when go is issued,
  // so the first WAIT cycle ignores done and the sticky flags start clear.
  logic                   r_left_seen;
  logic                   r_right_seen;
  logic                   r_wait_first;

  logic                   w_start_ok;
  logic                   w_left_ok;
  logic                   w_right_ok;
  logic                   w_both_ready;
  logic                   w_right_ready;
  logic                   w_last_pix;
  logic                   w_last_cand;
  logic                   w_better;
  logic [DATA_WIDTH-1:0]  w_ref_pix;
  logic [DATA_WIDTH-1:0]  w_cand_pix;
  logic [COST_WIDTH-1:0]  w_cost;

  assign w_start_ok    = start && r_armed;
  assign w_left_ok     = r_left_seen || left_done;
  assign w_right_ok    = r_right_seen || right_done;
  assign w_both_ready  = (r_state == ST_WAIT_BOTH) && !r_wait_first && w_left_ok && w_right_ok;
  assign w_right_ready = (r_state == ST_WAIT_RIGHT) && !r_wait_first && w_right_ok;
  assign w_last_pix    = (r_pix_cnt == PIX_W'(BLOCK_SIZE - 1));
  assign w_last_cand   = (r_cand == DISP_W'(MAX_DISPARITY - 1));
  assign w_better      = (r_sad < r_best_sad);

  // Pixel select in arrival order: pixel 0 is the most significant slot.
  always_comb begin
    w_ref_pix  = '0;
    w_cand_pix = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (r_pix_cnt == PIX_W'(i)) begin
        w_ref_pix  = r_ref[BLOCK_WIDTH-1-DATA_WIDTH*i -: DATA_WIDTH];
        w_cand_pix = r_cand_blk[BLOCK_WIDTH-1-DATA_WIDTH*i -: DATA_WIDTH];
      end
    end
  end

  comperator_axi_ip_v1_0_pixel_absdiff u_absdiff (
    .i_pix_a (w_ref_pix),
    .i_pix_b (w_cand_pix),
    .o_cost  (w_cost)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:        if (w_start_ok) w_state_nxt = ST_FETCH_BOTH;
      ST_FETCH_BOTH:  w_state_nxt = ST_WAIT_BOTH;
      ST_WAIT_BOTH:   if (w_both_ready) w_state_nxt = ST_ACCUM;
      ST_FETCH_RIGHT: w_state_nxt = ST_WAIT_RIGHT;
      ST_WAIT_RIGHT:  if (w_right_ready) w_state_nxt = ST_ACCUM;
      ST_ACCUM:       if (w_last_pix) w_state_nxt = ST_COMPARE;
      ST_COMPARE:     w_state_nxt = w_last_cand ? ST_RESULT : ST_FETCH_RIGHT;
      ST_RESULT:      if (r_result_valid && result_ready) w_state_nxt = ST_IDLE;
      default:        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_armed        <= 1'b0;
      r_busy         <= 1'b0;
      r_left_go      <= 1'b0;
      r_right_go     <= 1'b0;
      r_result_valid <= 1'b0;
      r_res_disp     <= '0;
      r_res_sad      <= '0;
      r_cand         <= '0;
      r_best_disp    <= '0;
      r_best_sad     <= '0;
      r_sad          <= '0;
      r_pix_cnt      <= '0;
      r_ref          <= '0;
      r_cand_blk     <= '0;
      r_left_seen    <= 1'b0;
      r_right_seen   <= 1'b0;
      r_wait_first   <= 1'b0;
    end else begin
      r_armed <= 1'b1;

      // Outputs are decoded from the next state so they line up with the
      // state they belong to while still coming straight from flops.
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_left_go      <= (w_state_nxt == ST_FETCH_BOTH);
      r_right_go     <= (w_state_nxt == ST_FETCH_BOTH) || (w_state_nxt == ST_FETCH_RIGHT);
      r_result_valid <= (w_state_nxt == ST_RESULT);

      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_cand      <= '0;
            r_best_disp <= '0;
            r_best_sad  <= '1;
          end
        end

        ST_FETCH_BOTH, ST_FETCH_RIGHT: begin
          r_left_seen  <= 1'b0;
          r_right_seen <= 1'b0;
          r_wait_first <= 1'b1;
        end

        ST_WAIT_BOTH, ST_WAIT_RIGHT: begin
          if (r_wait_first) begin
            r_wait_first <= 1'b0;
          end else begin
            r_left_seen  <= w_left_ok;
            r_right_seen <= w_right_ok;
          end
          if (w_both_ready) begin
            r_ref      <= left_block;
            r_cand_blk <= right_block;
          end
          if (w_right_ready) begin
            r_cand_blk <= right_block;
          end
          if (w_both_ready || w_right_ready) begin
            r_sad     <= '0;
            r_pix_cnt <= '0;
          end
        end

        ST_ACCUM: begin
          r_sad     <= r_sad + SAD_W'(w_cost);
          r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
        end

        ST_COMPARE: begin
          if (w_better) begin
            r_best_sad  <= r_sad;
            r_best_disp <= r_cand;
          end
          if (w_last_cand) begin
            r_res_sad  <= w_better ? r_sad : r_best_sad;
            r_res_disp <= w_better ? r_cand : r_best_disp;
          end else begin
            r_cand <= r_cand + 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  assign busy             = r_busy;
  assign left_go          = r_left_go;
  assign right_go         = r_right_go;
  assign result_valid     = r_result_valid;
  assign result_disparity = r_res_disp;
  assign result_sad       = r_res_sad;

endmodule

// File: tb/tb_comperator_axi_ip_v1_0_block_matcher.sv
// tb/tb_comperator_axi_ip_v1_0_block_matcher.sv - directed self-checking bench for the block matcher

module tb_comperator_axi_ip_v1_0_block_matcher;

  localparam int BS = 8;
  localparam int MD = 16;
  localparam int BW = BS * 24;

  logic          aclk;
  logic          aresetn;
  logic          start;
  logic          busy;
  logic          left_go;
  logic          left_done;
  logic [BW-1:0] left_block;
  logic          right_go;
  logic          right_done;
  logic [BW-1:0] right_block;
  logic          result_valid;
  logic          result_ready;
  logic [3:0]    result_disparity;
  logic [12:0]   result_sad;

  comperator_axi_ip_v1_0_block_matcher #(
    .BLOCK_SIZE    (BS),
    .MAX_DISPARITY (MD)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .start            (start),
    .busy             (busy),
    .left_go          (left_go),
    .left_done        (left_done),
    .left_block       (left_block),
    .right_go         (right_go),
    .right_done       (right_done),
    .right_block      (right_block),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_disparity (result_disparity),
    .result_sad       (result_sad)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int            n_chk;
  int            n_fail;
  int            lgo_cnt;
  int            rgo_cnt;
  int            r_idx;
  bit            use_rand;
  logic [BW-1:0] lblk;
  logic [BW-1:0] rblk [MD];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_l(input int i, input logic [23:0] v);
    lblk[BW-1-24*i -: 24] = v;
  endtask

  task automatic set_r(input int k, input int i, input logic [23:0] v);
    rblk[k][BW-1-24*i -: 24] = v;
  endtask

  // Reader models: done stays high (stale) through the first WAIT cycle,
  // then the new block appears after 0..20 extra cycles.
  initial begin : left_reader
    int d;
    forever begin
      @(negedge aclk);
      if (left_go === 1'b1) begin
        lgo_cnt++;
        d = use_rand ? int'($urandom_range(0, 20)) : 0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        if (d > 0) begin
          left_done = 1'b0;
          repeat (d) @(posedge aclk);
          #1;
        end
        left_block = lblk;
        left_done  = 1'b1;
      end
    end
  end

  initial begin : right_reader
    int d;
    int k;
    forever begin
      @(negedge aclk);
      if (right_go === 1'b1) begin
        rgo_cnt++;
        k = r_idx;
        r_idx++;
        d = use_rand ? int'($urandom_range(0, 20)) : 0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        if (d > 0) begin
          right_done = 1'b0;
          repeat (d) @(posedge aclk);
          #1;
        end
        right_block = (k < MD) ? rblk[k] : '0;
        right_done  = 1'b1;
      end
    end
  end

  task automatic run_match(input string tag, output logic [3:0] d, output logic [12:0] s, output int cyc);
    r_idx   = 0;
    lgo_cnt = 0;
    rgo_cnt = 0;
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    cyc = 1;
    while (result_valid !== 1'b1 && cyc < 5000) begin
      @(negedge aclk);
      cyc++;
    end
    check({tag, "_valid"}, result_valid, 1);
    d = result_disparity;
    s = result_sad;
  endtask

  task automatic fill_t1();
    for (int i = 0; i < BS; i++) begin
      set_l(i, 24'h101010);
      for (int k = 0; k < MD; k++) set_r(k, i, 24'h101010 + 24'(k));
    end
  endtask

  task automatic fill_t3();
    logic [23:0] base;
    for (int i = 0; i < BS; i++) begin
      base = {8'h10 + 8'(i), 8'h20, 8'h30};
      set_l(i, base);
      for (int k = 0; k < MD; k++) set_r(k, i, base + 24'h000010);
      set_r(3, i, base + 24'h030000);
      set_r(9, i, base);
    end
    set_r(9, 0, 24'h081C30);
    set_r(9, 7, 24'h17203C);
  endtask

  logic [3:0]  d;
  logic [12:0] s;
  int          cyc;
  int          unstable;

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    lgo_cnt      = 0;
    rgo_cnt      = 0;
    r_idx        = 0;
    use_rand     = 1'b0;
    aresetn      = 1'b0;
    start        = 1'b0;
    result_ready = 1'b1;
    left_done    = 1'b1;
    right_done   = 1'b1;
    left_block   = {8{24'hA5A5A5}};
    right_block  = {8{24'h5A5A5A}};
    lblk         = '0;
    for (int k = 0; k < MD; k++) rblk[k] = '0;

    repeat (3) @(negedge aclk);
    check("rst_busy", busy, 0);
    check("rst_go", {left_go, right_go}, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", {result_disparity, result_sad}, 0);

    // start coincident with reset release
    aresetn = 1'b1;
    start   = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (3) @(negedge aclk);
    check("release_start_busy", busy, 0);
    check("release_start_go", lgo_cnt, 0);

    // T1: uniform offsets, zero delay, ready held high throughout
    fill_t1();
    run_match("t1", d, s, cyc);
    check("t1_disp", d, 0);
    check("t1_sad", s, 0);
    check("t1_latency", cyc, 193);
    check("t1_left_go", lgo_cnt, 1);
    check("t1_right_go", rgo_cnt, 16);
    @(negedge aclk);
    check("t1_busy_after", busy, 0);
    check("t1_valid_after", result_valid, 0);

    // T2: only candidate 5 matches
    for (int i = 0; i < BS; i++) begin
      set_l(i, 24'hFFFFFF);
      for (int k = 0; k < MD; k++) set_r(k, i, 24'h000000);
      set_r(5, i, 24'hFFFFFF);
    end
    run_match("t2", d, s, cyc);
    check("t2_disp", d, 5);
    check("t2_sad", s, 0);

    // T2b: nothing matches, every SAD is 8*765
    for (int i = 0; i < BS; i++) set_r(5, i, 24'h000000);
    run_match("t2b", d, s, cyc);
    check("t2b_disp", d, 0);
    check("t2b_sad", s, 6120);

    // T3: candidates 3 and 9 tie at 24
    fill_t3();
    run_match("t3", d, s, cyc);
    check("t3_disp", d, 3);
    check("t3_sad", s, 24);

    // T4: same data, random asymmetric reader delays
    use_rand = 1'b1;
    run_match("t4", d, s, cyc);
    check("t4_disp", d, 3);
    check("t4_sad", s, 24);
    check("t4_left_go", lgo_cnt, 1);
    check("t4_right_go", rgo_cnt, 16);
    use_rand = 1'b0;
    @(negedge aclk);

    // T5: result held with ready low; start during hold ignored
    for (int i = 0; i < BS; i++) set_r(5, i, 24'hFFFFFF);
    for (int i = 0; i < BS; i++) set_l(i, 24'hFFFFFF);
    result_ready = 1'b0;
    run_match("t5", d, s, cyc);
    check("t5_disp", d, 5);
    unstable = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      start = (n == 25);
      if (result_valid !== 1'b1 || result_disparity !== d || result_sad !== s || busy !== 1'b1)
        unstable++;
    end
    start = 1'b0;
    check("t5_hold_stable", unstable, 0);
    check("t5_no_go_in_hold", {lgo_cnt[15:0], rgo_cnt[15:0]}, {16'd1, 16'd16});
    result_ready = 1'b1;
    @(negedge aclk);
    check("t5_busy_drop", busy, 0);
    check("t5_valid_drop", result_valid, 0);
    repeat (3) @(negedge aclk);
    check("t5_no_restart", lgo_cnt, 1);

    // T6: reset during ACCUM of candidate 7, then a full match
    fill_t1();
    r_idx   = 0;
    lgo_cnt = 0;
    rgo_cnt = 0;
    start   = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int n = 1; n < 90; n++) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_go", {left_go, right_go}, 0);
    check("t6_rst_valid", result_valid, 0);
    check("t6_rst_result", {result_disparity, result_sad}, 0);
    check("t6_right_go_before", rgo_cnt, 8);
    repeat (5) @(negedge aclk);
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    check("t6_no_go_after_rst", {lgo_cnt[15:0], rgo_cnt[15:0]}, {16'd1, 16'd8});
    check("t6_idle_after_rst", busy, 0);
    fill_t3();
    run_match("t6", d, s, cyc);
    check("t6_disp", d, 3);
    check("t6_sad", s, 24);
    check("t6_right_go", rgo_cnt, 16);
    @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
